// File: rtl/data_sram_responder.sv
// ============================================================================
// Module      : data_sram_responder
// Description : Data-side SRAM-handshake responder with an internal word RAM
//               and an in-order response queue with a fixed minimum latency.
//               Optional random stalls are enabled by DATA_SRAM_RAND_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_sram_responder #(
    parameter int          ADDR_BITS       = 12,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          LATENCY         = 2,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int AGE_W = $clog2(LATENCY + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_OUTSTANDING);

    logic [31:0]          ram    [0:(1<<ADDR_BITS)-1];
    logic [31:0]          q_data [MAX_OUTSTANDING];
    logic [AGE_W-1:0]     q_age  [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [ADDR_BITS-1:0] index;
    logic [31:0]          in_data;
    logic [31:0]          head_age;
    logic                 accept;
    logic                 pop;
    logic                 bypass;
    logic                 push;
    logic                 accept_gate;
    logic                 issue_gate;
    logic                 unused_bits;

`ifdef DATA_SRAM_RAND_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign accept_gate = lfsr[0];
    assign issue_gate  = lfsr[1];
`else
    assign accept_gate = 1'b1;
    assign issue_gate  = 1'b1;
`endif

    assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_BITS+2], data_sram_addr[1:0]};

    assign index             = data_sram_addr[ADDR_BITS+1:2];
    assign data_sram_addr_ok = resetn & data_sram_req & (count < MAX_COUNT) & accept_gate;
    assign accept            = data_sram_addr_ok;
    assign in_data           = data_sram_wr ? 32'h0 : ram[index];

    // Age counts edges since the handshake; popping when age+1 reaches
    // LATENCY puts data_ok exactly LATENCY cycles after the handshake cycle.
    assign head_age = 32'(q_age[rd_ptr]);
    assign pop      = (count != '0) && ((head_age + 32'd1) >= 32'(LATENCY)) && issue_gate;
    assign bypass   = (LATENCY == 1) && (count == '0) && accept && issue_gate;
    assign push     = accept && !bypass;

    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    ram[index][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            data_sram_data_ok <= 1'b0;
            data_sram_rdata   <= 32'h0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_data[i] <= 32'h0;
                q_age[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (q_age[i] < AGE_W'(LATENCY)) begin
                    q_age[i] <= q_age[i] + AGE_W'(1);
                end
            end
            if (push) begin
                q_data[wr_ptr] <= in_data;
                q_age[wr_ptr]  <= AGE_W'(1);
                wr_ptr         <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            count             <= count + CNT_W'(push) - CNT_W'(pop);
            data_sram_data_ok <= pop | bypass;
            if (pop) begin
                data_sram_rdata <= q_data[rd_ptr];
            end else if (bypass) begin
                data_sram_rdata <= in_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed vector table plus multi-cycle
// sequences for pointer wrap, full-queue stalls and mid-flight reset.
`default_nettype none

module tb_data_sram_responder;

    typedef struct {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ok;
        logic        exp_dok;
        logic        chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0, wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    logic        f_req = 1'b0;
    logic [31:0] f_wdata = 32'h0;
    logic        f_addr_ok, f_data_ok;
    logic [31:0] f_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [13];

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_BITS(12), .MAX_OUTSTANDING(4), .LATENCY(2)) dut (
        .clk(clk), .resetn(resetn),
        .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
        .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
        .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata)
    );

    data_sram_responder #(.ADDR_BITS(8), .MAX_OUTSTANDING(2), .LATENCY(4)) dut_full (
        .clk(clk), .resetn(resetn),
        .data_sram_req(f_req), .data_sram_wr(1'b1), .data_sram_size(2'd2),
        .data_sram_wstrb(4'hF), .data_sram_addr(32'h0000_0010), .data_sram_wdata(f_wdata),
        .data_sram_addr_ok(f_addr_ok), .data_sram_data_ok(f_data_ok), .data_sram_rdata(f_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [1:0] s, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = r; wr = w; size = s; wstrb = st; addr = a; wdata = d;
        #1;
    endtask

    initial begin
        logic [9:0] f_ok_pat;
        logic [9:0] f_dok_pat;

        vecs[0]  = '{1'b1, 1'b1, 2'd2, 4'hF, 32'h40,   32'h1122_3344, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h40,   32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,    32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,    32'h0,         1'b0, 1'b1, 1'b1, 32'h1122_3344};
        vecs[4]  = '{1'b1, 1'b1, 2'd0, 4'h4, 32'h40,   32'hAABB_CCDD, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 2'd0, 4'h0, 32'h40,   32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,    32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,    32'h0,         1'b0, 1'b1, 1'b1, 32'h11BB_3344};
        vecs[8]  = '{1'b1, 1'b1, 2'd0, 4'h1, 32'h4040, 32'h5566_7788, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h40,   32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,    32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,    32'h0,         1'b0, 1'b1, 1'b1, 32'h11BB_3388};
        vecs[12] = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0,    32'h0,         1'b0, 1'b0, 1'b0, 32'h0};

        // Reset held with requests pending: nothing may be accepted or returned.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0);
            f_req = 1'b1;
            #1;
            chk("rst_addr_ok", {31'h0, addr_ok}, 32'h0);
            chk("rst_data_ok", {31'h0, data_ok}, 32'h0);
            chk("rst_rdata", rdata, 32'h0);
            chk("rst_full_addr_ok", {31'h0, f_addr_ok}, 32'h0);
        end
        resetn = 1'b1;
        #1;
        chk("release_addr_ok", {31'h0, addr_ok}, 32'h1);
        req = 1'b0;
        f_req = 1'b0;

        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].req, vecs[i].wr, vecs[i].size, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_addr_ok", i), {31'h0, addr_ok}, {31'h0, vecs[i].exp_ok});
            chk($sformatf("vec%0d_data_ok", i), {31'h0, data_ok}, {31'h0, vecs[i].exp_dok});
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end

        // 16 writes of index to words 0..15, then 16 reads, all back to back.
        for (int k = 0; k < 35; k++) begin
            if (k < 16)      cyc(1'b1, 1'b1, 2'd2, 4'hF, 32'(4*k), 32'(k));
            else if (k < 32) cyc(1'b1, 1'b0, 2'd2, 4'h0, 32'(4*(k-16)), 32'h0);
            else             cyc(1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0);
            chk($sformatf("wrap%0d_addr_ok", k), {31'h0, addr_ok}, (k < 32) ? 32'h1 : 32'h0);
            chk($sformatf("wrap%0d_data_ok", k), {31'h0, data_ok},
                (k >= 2 && k < 34) ? 32'h1 : 32'h0);
            if (k >= 2 && k < 34)
                chk($sformatf("wrap%0d_rdata", k), rdata, (k < 18) ? 32'h0 : 32'(k - 18));
        end

        // Queue of 2 with latency 4 under a continuously held request.
        f_ok_pat  = 10'b1100110011;
        f_dok_pat = 10'b1100110000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            f_req = 1'b1;
            f_wdata = 32'(k);
            #1;
            chk($sformatf("full%0d_addr_ok", k), {31'h0, f_addr_ok}, {31'h0, f_ok_pat[k]});
            chk($sformatf("full%0d_data_ok", k), {31'h0, f_data_ok}, {31'h0, f_dok_pat[k]});
            if (f_dok_pat[k]) chk($sformatf("full%0d_rdata", k), f_rdata, 32'h0);
        end
        @(negedge clk);
        f_req = 1'b0;

        // Reset with reads in flight drops them.
        cyc(1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0);
        chk("mid_acc0", {31'h0, addr_ok}, 32'h1);
        cyc(1'b1, 1'b0, 2'd2, 4'h0, 32'h4, 32'h0);
        chk("mid_acc1", {31'h0, addr_ok}, 32'h1);
        cyc(1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0);
        chk("mid_first_dok", {31'h0, data_ok}, 32'h1);
        resetn = 1'b0;
        #1;
        chk("mid_async_dok", {31'h0, data_ok}, 32'h0);
        chk("mid_async_rdata", rdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 2'd2, 4'h0, 32'h8, 32'h0);
            chk($sformatf("mid_rst%0d_dok", i), {31'h0, data_ok}, 32'h0);
            chk($sformatf("mid_rst%0d_addr_ok", i), {31'h0, addr_ok}, 32'h0);
        end
        req = 1'b0;
        resetn = 1'b1;
        cyc(1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0);
        chk("mid_post_idle_dok", {31'h0, data_ok}, 32'h0);
        cyc(1'b1, 1'b0, 2'd2, 4'h0, 32'h14, 32'h0);
        chk("mid_new_acc", {31'h0, addr_ok}, 32'h1);
        cyc(1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0);
        chk("mid_new_dok_l1", {31'h0, data_ok}, 32'h0);
        cyc(1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0);
        chk("mid_new_dok_l2", {31'h0, data_ok}, 32'h1);
        chk("mid_new_rdata", rdata, 32'h5);
        cyc(1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0);
        chk("mid_new_dok_l3", {31'h0, data_ok}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
